// File: rtl/ones_sub_sched_if.sv
// Handshake/result bundle between the two requesters and the shared subtractor scheduler.
interface ones_sub_sched_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             res_valid;
    logic             res_id;
    logic [WIDTH-1:0] res;
    logic             res_neg;

    // Client side: drives requests and operands, observes grants and results.
    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, res_valid, res_id, res, res_neg
    );

    // Scheduler side.
    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, res_valid, res_id, res, res_neg
    );
endinterface

// File: rtl/ones_sub_sched.sv
// Round-robin scheduler and two-pass sequencer for a shared one's-complement subtractor (A-B).
// Optional macro SUB_MAG_EN adds a MAG pass that converts negative results to unsigned magnitude.
module ones_sub_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ones_sub_sched_if.slave bus
);
    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        EAC  = 3'd2,
`ifdef SUB_MAG_EN
        MAG  = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             cur_id_q, cur_id_d;
    logic             last_id_q, last_id_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_neg_q, res_neg_d;

    logic [WIDTH-1:0] not_b;
    logic [SUM_W-1:0] first_sum;
    logic             win0, win1;

    // First adder pass operand and round-robin winner selection.
    always_comb begin
        not_b     = ~op_b_q;
        first_sum = {1'b0, op_a_q} + {1'b0, not_b};
        win0      = bus.req0 & (~bus.req1 | last_id_q);
        win1      = bus.req1 & (~bus.req0 | ~last_id_q);
    end

    // Next-state and next-register values.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        y_d         = y_q;
        carry_d     = carry_q;
        neg_d       = neg_q;
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_d       = res_q;
        res_neg_d   = res_neg_q;
        unique case (state_q)
            IDLE: begin
                if (win0) begin
                    op_a_d    = bus.a0;
                    op_b_d    = bus.b0;
                    cur_id_d  = 1'b0;
                    last_id_d = 1'b0;
                    gnt0_d    = 1'b1;
                    state_d   = ADD;
                end else if (win1) begin
                    op_a_d    = bus.a1;
                    op_b_d    = bus.b1;
                    cur_id_d  = 1'b1;
                    last_id_d = 1'b1;
                    gnt1_d    = 1'b1;
                    state_d   = ADD;
                end
            end
            ADD: begin
                {carry_d, y_d} = first_sum;
                state_d        = EAC;
            end
            EAC: begin
                y_d   = y_q + WIDTH'(carry_q);
                neg_d = ~carry_q;
`ifdef SUB_MAG_EN
                state_d = MAG;
`else
                state_d = DONE;
`endif
            end
`ifdef SUB_MAG_EN
            MAG: begin
                if (neg_q) begin
                    y_d = ~y_q;
                    if (~y_q == '0) begin
                        neg_d = 1'b0;
                    end
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                res_d       = y_q;
                res_neg_d   = neg_q;
                res_id_d    = cur_id_q;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            y_q         <= '0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_q       <= '0;
            res_neg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            y_q         <= y_d;
            carry_q     <= carry_d;
            neg_q       <= neg_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_q       <= res_d;
            res_neg_q   <= res_neg_d;
        end
    end

    // Drive the bundle from the registered outputs.
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res       = res_q;
    assign bus.res_neg   = res_neg_q;
endmodule

// File: tb/tb_ones_sub_sched.sv
// Directed scoreboard bench for ones_sub_sched (honours SUB_MAG_EN when defined).
module tb_ones_sub_sched;
    localparam int unsigned WIDTH = 4;
`ifdef SUB_MAG_EN
    localparam int LAT = 4;
    localparam bit MAG = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit MAG = 1'b0;
`endif

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] res;
        logic             neg;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ones_sub_sched_if #(.WIDTH(WIDTH)) bus ();

    ones_sub_sched #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic difference mapped to the expected output encoding.
    function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] mag;
        e.id = id;
        if (a > b) begin
            e.res = a - b;
            e.neg = 1'b0;
        end else if (a == b) begin
            e.res = MAG ? '0 : '1;
            e.neg = ~MAG;
        end else begin
            mag   = b - a;
            e.res = MAG ? mag : ~mag;
            e.neg = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for any grant; returns which requester got it.
    task automatic wait_gnt(output logic id, output bit ok);
        ok = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
                ok = 1'b1;
                id = bus.gnt1;
                break;
            end
        end
        chk("gnt_seen", 32'(ok), 32'd1);
        if (ok) chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_id"}, 32'(bus.res_id), 32'd0);
        chk({tag, "_res"}, 32'(bus.res), 32'd0);
        chk({tag, "_neg"}, 32'(bus.res_neg), 32'd0);
    endtask

    // Single request from one requester, latency and idle-return checked.
    task automatic run_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic gid;
        bit   ok;
        if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
        else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
        wait_gnt(gid, ok);
        if (ok) begin
            chk("op_gnt_id", 32'(gid), 32'(id));
            chk("op_busy", 32'(bus.busy), 32'd1);
            sb.push_back(model(gid, a, b));
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            repeat (LAT - 1) step();
            chk("op_valid_early", 32'(bus.res_valid), 32'd0);
            step();
            chk("op_valid_lat", 32'(bus.res_valid), 32'd1);
            step();
            chk("op_valid_pulse", 32'(bus.res_valid), 32'd0);
            chk("op_idle", 32'(bus.busy), 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_res", 32'(bus.res), 32'(e.res));
                chk("sb_neg", 32'(bus.res_neg), 32'(e.neg));
                chk("sb_id", 32'(bus.res_id), 32'(e.id));
            end
        end
    end

    initial begin
        logic gid;
        bit   ok;
        logic exp_id;

        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        rst_n = 1'b0;
        repeat (2) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Basic arithmetic cases.
        run_op(1'b0, 4'b0111, 4'b0011);
        run_op(1'b1, 4'b0011, 4'b0111);
        run_op(1'b0, 4'b0101, 4'b0101);
        run_op(1'b1, 4'b0000, 4'b1111);
        run_op(1'b0, 4'b1111, 4'b0000);

        // Tie straight out of reset: req0 first, req1 exactly LAT+1 cycles later.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 4'b0111; bus.b0 = 4'b0011;
        bus.req1 = 1'b1; bus.a1 = 4'b0011; bus.b1 = 4'b0111;
        step();
        chk("tie_gnt0", 32'(bus.gnt0), 32'd1);
        chk("tie_gnt1_first", 32'(bus.gnt1), 32'd0);
        sb.push_back(model(1'b0, 4'b0111, 4'b0011));
        bus.req0 = 1'b0;
        repeat (LAT) step();
        chk("tie_gnt1_early", 32'(bus.gnt1), 32'd0);
        step();
        chk("tie_gnt1", 32'(bus.gnt1), 32'd1);
        sb.push_back(model(1'b1, 4'b0011, 4'b0111));
        bus.req1 = 1'b0;
        repeat (LAT + 1) step();

        // Both held continuously: grants alternate 0,1,0,1.
        bus.a0 = 4'b1000; bus.b0 = 4'b0001;
        bus.a1 = 4'b0010; bus.b1 = 4'b1010;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        exp_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(gid, ok);
            if (ok) begin
                chk("rr_order", 32'(gid), 32'(exp_id));
                sb.push_back(gid ? model(1'b1, bus.a1, bus.b1) : model(1'b0, bus.a0, bus.b0));
            end
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            exp_id = ~exp_id;
        end
        repeat (LAT + 2) step();

        // Reset during EAC aborts the op and restores last_id so req0 wins the next tie.
        bus.req0 = 1'b1; bus.a0 = 4'b0110; bus.b0 = 4'b0001;
        wait_gnt(gid, ok);
        chk("abort_gnt_id", 32'(gid), 32'd0);
        bus.req0 = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (LAT + 1) step();
        chk("abort_no_valid", 32'(bus.res_valid), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        bus.req0 = 1'b1; bus.a0 = 4'b0110; bus.b0 = 4'b0001;
        bus.req1 = 1'b1; bus.a1 = 4'b0001; bus.b1 = 4'b0110;
        wait_gnt(gid, ok);
        chk("post_rst_tie", 32'(gid), 32'd0);
        if (ok) sb.push_back(model(gid, gid ? bus.a1 : bus.a0, gid ? bus.b1 : bus.b0));
        if (gid) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        wait_gnt(gid, ok);
        chk("post_rst_second", 32'(gid), 32'd1);
        if (ok) sb.push_back(model(gid, gid ? bus.a1 : bus.a0, gid ? bus.b1 : bus.b0));
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (LAT + 2) step();

        // Operand changes after the grant are ignored; req1 raised while busy waits for IDLE.
        bus.req0 = 1'b1; bus.a0 = 4'b0111; bus.b0 = 4'b0011;
        wait_gnt(gid, ok);
        chk("capture_gnt_id", 32'(gid), 32'd0);
        sb.push_back(model(1'b0, 4'b0111, 4'b0011));
        bus.req0 = 1'b0;
        step();
        bus.a0 = 4'b0000; bus.b0 = 4'b1111;
        bus.req1 = 1'b1; bus.a1 = 4'b1001; bus.b1 = 4'b0010;
        repeat (LAT - 1) begin
            step();
            chk("busy_no_gnt1", 32'(bus.gnt1), 32'd0);
        end
        step();
        chk("busy_gnt1_after_done", 32'(bus.gnt1), 32'd1);
        sb.push_back(model(1'b1, 4'b1001, 4'b0010));
        bus.req1 = 1'b0;
        repeat (LAT + 2) step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ones_sub_sched.md
Name: ones_sub_sched

Overview:
- Scheduler and sequencer for a shared WIDTH-bit one's-complement subtractor datapath computing A-B.
- Two requesters share one adder. Round-robin arbitration picks one of them.
- Each operation runs as two adder passes: a first pass A + ~B, then an end-around-carry pass Y + carry.
- Returns the result, a sign flag and the requester id with a one-cycle valid pulse. Sits between client blocks and the shared adder.

Parameters:
- WIDTH, 4, operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  requester 0 request; held until gnt0.
- a0  input  WIDTH  requester 0 minuend.
- b0  input  WIDTH  requester 0 subtrahend.
- req1  input  1  requester 1 request; held until gnt1.
- a1  input  WIDTH  requester 1 minuend.
- b1  input  WIDTH  requester 1 subtrahend.
- gnt0  output  1  one-cycle pulse: req0 accepted, operands captured.
- gnt1  output  1  one-cycle pulse: req1 accepted, operands captured.
- busy  output  1  high in every state except IDLE.
- res_valid  output  1  one-cycle pulse: result outputs valid.
- res_id  output  1  requester that owns the result.
- res  output  WIDTH  subtraction result.
- res_neg  output  1  1 = negative result (first-pass carry was 0).

Behaviour:
- Reset (rst_n low at a clk edge) forces these values:
  - state = IDLE.
  - gnt0, gnt1, busy, res_valid, res_id, res_neg = 0; res = 0.
  - internal op_a, op_b, y, carry = 0; last_id = 1, so req0 wins the first tie.
- Reset mid-operation aborts the in-flight op. No res_valid is produced, and the requester gets no retry.
- FSM states: IDLE -> ADD -> EAC -> DONE -> IDLE. With SUB_MAG_EN the path is IDLE -> ADD -> EAC -> MAG -> DONE -> IDLE.
- IDLE:
  - If neither request is high, stay.
  - If exactly one request is high, grant it.
  - If both are high, grant the one not equal to last_id.
  - On grant, at the same edge: latch op_a/op_b from the winner, set cur_id and last_id to the winner, register gntX = 1 for exactly one cycle, go to ADD.
- ADD: {carry, y} <= op_a + ~op_b (WIDTH+1-bit sum). Go to EAC.
- EAC:
  - y <= y + carry, truncated to WIDTH bits; res_neg_int <= ~carry.
  - y = all-ones with carry = 1 cannot occur, so the second pass never overflows.
- DONE:
  - res, res_neg and res_id are driven from the registers; res_valid = 1 for this cycle only. Go to IDLE.
  - res/res_neg/res_id hold their values until the next DONE or reset.
- Latency: request sampled at edge t -> gnt high during cycle t..t+1 -> res_valid high during cycle t+3..t+4 (t+4..t+5 with SUB_MAG_EN). Earliest next grant is at edge t+4.
- Negative result (feature off): res is the one's-complement encoding of |A-B|, e.g. 3-7 -> 1011.
- A == B: first pass gives all-ones with carry 0, so res = all-ones and res_neg = 1 (negative zero) when the feature is off.
- A request that is still high after its gnt is treated as a new request. Requesters must drop req in the gnt cycle.
- Requests arriving while busy are ignored until IDLE; they are not queued.
- Operand inputs are sampled only at the grant edge; later changes have no effect.

Optional Feature:
- Macro: SUB_MAG_EN.
- Defined:
  - An extra MAG state sits between EAC and DONE.
  - If res_neg_int = 1, y <= ~y, so res is the unsigned magnitude |A-B|.
  - If the inverted y is zero (A == B), res_neg is cleared to 0, so there is no negative zero.
  - Latency increases by one cycle.
- Not defined: no MAG state; res stays in one's-complement form and negative zero is reported as all-ones with res_neg = 1.

Test Plan:
- req0, a0=0111, b0=0011 -> gnt0 pulse; 3 cycles after grant edge: res_valid=1, res=0100, res_neg=0, res_id=0.
- req1, a1=0011, b1=0111 -> res=1011, res_neg=1, res_id=1. With SUB_MAG_EN: res=0100, res_neg=1, res_valid one cycle later.
- req0 (0101-0101) -> res=1111, res_neg=1. With SUB_MAG_EN: res=0000, res_neg=0.
- req0 and req1 asserted together from reset, each held until its grant -> gnt0 first, then gnt1 four cycles later; res_id sequence 0,1. Repeat with both held continuously -> grants alternate 0,1,0,1.
- Grant req0 (0110-0001), assert rst_n=0 in EAC -> next cycle all outputs 0, no res_valid. After release, a simultaneous req0/req1 grants req0 (last_id reset to 1).
- Change a0/b0 in the cycle after gnt0 -> result reflects the operands captured at the grant edge; req1 raised while busy -> granted only after DONE.
